// File: rtl/l1p4.sv
// l1p4 : registered one-bit full-adder cell.
//
// Each rising clk samples operand bits A, B and D (carry-in). One cycle
// later it presents the carry on C and the sum on E, so that {C,E} is the
// 2-bit unsigned sum A+B+D. The cell is the leaf of ripple-adder and parity
// structures in the logic-lab datapath.
//
// Ports (declaration order is fixed so positional instances keep binding):
//   C       out  1  registered carry, majority(A,B,D)
//   E       out  1  registered sum, A^B^D
//   A       in   1  operand bit 0
//   B       in   1  operand bit 1
//   D       in   1  operand bit 2 (carry-in)
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset
//   cov     out  8  sticky mask of {A,B,D} vectors seen since reset
//                   (L1P4_COVER_EN only)
//   cov_all out  1  high when every vector has been seen (L1P4_COVER_EN only)
//
// Build option:
//   L1P4_COVER_EN  adds the input-coverage tracker (cov / cov_all).
//                  Without it the tracker and its ports do not exist; the
//                  C/E datapath is identical in both builds.

module l1p4 (
    output logic       C,
    output logic       E,
    input  logic       A,
    input  logic       B,
    input  logic       D,
    input  logic       clk,
    input  logic       rst
`ifdef L1P4_COVER_EN
    ,
    output logic [7:0] cov,
    output logic       cov_all
`endif
);

    logic c_d, c_q;
    logic e_d, e_q;

    // No input masking: an X/Z on any operand flows straight through to
    // the registered outputs.
    always_comb begin
        c_d = (A & B) | (A & D) | (B & D);
        e_d = A ^ B ^ D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            e_q <= 1'b0;
        end else begin
            c_q <= c_d;
            e_q <= e_d;
        end
    end

    assign C = c_q;
    assign E = e_q;

`ifdef L1P4_COVER_EN
    logic [7:0] cov_d, cov_q;

    // The case items are fully known constants, so a vector holding X/Z
    // matches none of them and falls to the default: nothing gets set.
    always_comb begin
        cov_d = cov_q;
        case ({A, B, D})
            3'b000:  cov_d[0] = 1'b1;
            3'b001:  cov_d[1] = 1'b1;
            3'b010:  cov_d[2] = 1'b1;
            3'b011:  cov_d[3] = 1'b1;
            3'b100:  cov_d[4] = 1'b1;
            3'b101:  cov_d[5] = 1'b1;
            3'b110:  cov_d[6] = 1'b1;
            3'b111:  cov_d[7] = 1'b1;
            default: cov_d = cov_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cov_q <= 8'h00;
        end else begin
            cov_q <= cov_d;
        end
    end

    assign cov     = cov_q;
    assign cov_all = &cov_q;
`endif

endmodule

// File: tb/tb_l1p4.sv
module tb_l1p4;

    logic clk = 1'b0;
    logic rst;
    logic A, B, D;
    logic C, E;
`ifdef L1P4_COVER_EN
    logic [7:0] cov;
    logic       cov_all;
    logic [7:0] cov_m;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l1p4 dut (
        .C       (C),
        .E       (E),
        .A       (A),
        .B       (B),
        .D       (D),
        .clk     (clk),
        .rst     (rst)
`ifdef L1P4_COVER_EN
        ,
        .cov     (cov),
        .cov_all (cov_all)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: after an edge the outputs equal the arithmetic sum of the
    // bits sampled at that edge, or zero if reset was sampled.
    task automatic step(input logic a, input logic b, input logic d, input logic r,
                        input string tag);
        int   s;
        logic [7:0] exp;
        A = a; B = b; D = d; rst = r;
        @(posedge clk);
        #1;
        s   = (r ? 0 : int'(a) + int'(b) + int'(d));
        exp = 8'(s);
        check($sformatf("%s ce abd=%b%b%b rst=%b", tag, a, b, d, r), {6'b0, C, E}, exp);
`ifdef L1P4_COVER_EN
        if (r) cov_m = 8'h00;
        else   cov_m[int'(a) * 4 + int'(b) * 2 + int'(d)] = 1'b1;
        check($sformatf("%s cov", tag), cov, cov_m);
        check($sformatf("%s cov_all", tag), {7'b0, cov_all}, {7'b0, cov_m == 8'hFF});
`endif
    endtask

    initial begin
        logic [2:0] v;
        logic [1:0] sweep_exp [8];
        sweep_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
`ifdef L1P4_COVER_EN
        cov_m = 8'h00;
`endif
        A = 1'b1; B = 1'b1; D = 1'b1; rst = 1'b1;
        #2;

        // Reset held two cycles with all operands high.
        step(1, 1, 1, 1, "reset0");
        step(1, 1, 1, 1, "reset1");

        // Exhaustive sweep, also compared against the literal truth table.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(v[2], v[1], v[0], 0, "sweep");
            check($sformatf("sweep_tt %0d", i), {6'b0, C, E}, {6'b0, sweep_exp[i]});
        end
`ifdef L1P4_COVER_EN
        check("cov_full", cov, 8'hFF);
        check("cov_all_full", {7'b0, cov_all}, 8'h01);
`endif

        // Latency: A rises with B=1, D=0; C must not move before the edge.
        step(0, 1, 0, 0, "lat_pre");
        A = 1'b1;
        #2;
        check("lat_no_early", {7'b0, C}, 8'h00);
        step(1, 1, 0, 0, "lat_post");
        check("lat_c_high", {7'b0, C}, 8'h01);

        // Mid-stream one-cycle reset while streaming 111.
        step(1, 1, 1, 0, "stream");
        step(1, 1, 1, 0, "stream");
        step(1, 1, 1, 1, "mid_rst");
        check("mid_rst_zero", {6'b0, C, E}, 8'h00);
        step(1, 1, 1, 0, "mid_resume");
        check("mid_resume_11", {6'b0, C, E}, 8'h03);

        // Coverage after reset with only 011 applied.
        step(0, 0, 0, 1, "cov_rst");
`ifdef L1P4_COVER_EN
        check("cov_cleared", cov, 8'h00);
        check("cov_all_cleared", {7'b0, cov_all}, 8'h00);
`endif
        step(0, 1, 1, 0, "only011");
        step(0, 1, 1, 0, "only011");
`ifdef L1P4_COVER_EN
        check("cov_only011", cov, 8'h08);
`endif

        // Randomized vectors with occasional reset pulses.
        for (int i = 0; i < 1000; i++) begin
            v = 3'($urandom_range(0, 7));
            step(v[2], v[1], v[0], ($urandom_range(0, 19) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1p4.md
# l1p4

Registered one-bit full-adder cell: every clock it samples three single-bit operands A, B and D. It drives the carry on C and the sum on E, one cycle later. It is the leaf arithmetic cell for ripple-adder and parity structures in the logic-lab datapath. An optional coverage tracker records which of the eight input combinations have been applied since reset.

## Interface
Parameters:
- None. Widths are fixed at one bit per operand.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset; synchronous and active-high.
- C  output  1  registered carry, majority(A,B,D).
- E  output  1  registered sum, A^B^D.
- A  input  1  operand bit 0.
- B  input  1  operand bit 1.
- D  input  1  operand bit 2 (carry-in).
- cov  output  8  coverage mask; present only with L1P4_COVER_EN.
- cov_all  output  1  high when cov == 8'hFF; present only with L1P4_COVER_EN.

Declaration order is C, E, A, B, D, clk, rst, then cov and cov_all. The first five positions are fixed so that existing positional instantiations (C,E,A,B,D,...) keep binding correctly.

## Operation
- Combinational next-state:
  - c_n = (A&B) | (A&D) | (B&D)
  - e_n = A ^ B ^ D
- On each rising clk with rst=0: C <= c_n, E <= e_n.
- Truth table, index {A,B,D} -> {C,E}:
  - 000->00, 001->01, 010->01, 011->10
  - 100->01, 101->10, 110->10, 111->11
- Arithmetic identity: {C,E} == A + B + D as a 2-bit unsigned sum. This must hold for every sampled vector.
- Reset on a rising clk with rst=1:
  - C <= 0, E <= 0, cov <= 8'h00.
  - Inputs sampled in the same cycle are discarded.
- Reset has priority over every other update, including mid-stream.
- X or Z on any input propagates to the outputs as X. The block does no input masking.
- No internal state other than the output registers and the optional cov register.

## Timing
- Latency: exactly 1 clk. Outputs reflect the inputs sampled at the previous rising edge.
- Throughput: one result per clock, with no stall and no handshake.
- Outputs are glitch-free: they change only at rising clk edges.
- First valid result appears on the first rising edge after rst deasserts.
- Inputs must meet setup/hold to clk. No asynchronous path exists from A/B/D to C/E.
- If rst is asserted for a single cycle mid-stream:
  - The outputs read 0/0 for exactly that cycle.
  - Normal tracking resumes on the next edge.

## Configuration
- L1P4_COVER_EN defined:
  - Adds an 8-bit register cov and the cov_all output.
  - On each non-reset edge, cov[{A,B,D}] <= 1, where {A,B,D} is the 3-bit index.
  - Bits are sticky until reset. Set bits are never cleared by input activity.
  - cov_all is combinational from cov and is high iff all eight bits are set.
  - Sampling a vector containing X/Z does not set any bit.
- L1P4_COVER_EN undefined:
  - cov and cov_all ports are absent; no coverage logic is synthesized.
  - C/E behaviour is identical in both builds.

## Test plan
- Reset check: hold rst=1 for 2 cycles with A=B=D=1 -> C=0, E=0 and, with the macro, cov=8'h00.
- Exhaustive sweep: apply {A,B,D}=000..111, one per cycle, with rst=0 -> one cycle later {C,E}=00,01,01,10,01,10,10,11.
- Latency check: change A from 0 to 1 with B=1, D=0 -> C goes 0->1 on the next edge, not earlier.
- Mid-stream reset: streaming 111, pulse rst for one cycle -> {C,E}=00 for that cycle, then 11 on the following edge.
- Coverage (macro on):
  - After the full sweep -> cov=8'hFF, cov_all=1.
  - Apply rst -> cov=8'h00, cov_all=0.
  - Apply only 011 -> cov=8'h08.
- Randomized check: 1000 random vectors -> {C,E} == A+B+D of the previous-cycle inputs on every cycle.
